// File: rtl/jtframe_joy_serial_if.sv
// -----------------------------------------------------------------------------
// jtframe_joy_serial_if
// Bundles the shift-register chain lines and the joystick-side signals of the
// serial joystick front-end.
//   en, swap    : scan enable / joystick output swap      (into the front-end)
//   JOY_LOAD    : parallel load to the chain, active low  (out of the front-end)
//   JOY_CLK     : shift clock to the chain, idles low     (out of the front-end)
//   JOY_DATA    : serial data from the chain, active low  (into the front-end)
//   joy1, joy2  : debounced active-high joystick words    (out of the front-end)
//   frame_done  : one-cycle pulse per completed frame     (out of the front-end)
// The master modport is the front-end; the slave modport is the board side.
// -----------------------------------------------------------------------------
interface jtframe_joy_serial_if #(
    parameter int NBITS = 16
);
    logic               en;
    logic               swap;
    logic               JOY_LOAD;
    logic               JOY_CLK;
    logic               JOY_DATA;
    logic [NBITS/2-1:0] joy1;
    logic [NBITS/2-1:0] joy2;
    logic               frame_done;

    modport master (
        input  en, swap, JOY_DATA,
        output JOY_LOAD, JOY_CLK, joy1, joy2, frame_done
    );

    modport slave (
        output en, swap, JOY_DATA,
        input  JOY_LOAD, JOY_CLK, joy1, joy2, frame_done
    );
endinterface

// File: rtl/jtframe_joy_serial.sv
// -----------------------------------------------------------------------------
// jtframe_joy_serial
// Serial joystick front-end: scans a 74HC165-style chain once per SCAN cycles,
// captures NBITS bits MSB first, debounces by requiring two identical frames
// and presents the result as active-high joystick words.
//   clk_sys : system clock, rising edge
//   rst_n   : asynchronous active-low reset (release synchronized internally)
//   bus     : jtframe_joy_serial_if master (en, swap, JOY_LOAD, JOY_CLK,
//             JOY_DATA, joy1, joy2, frame_done)
// -----------------------------------------------------------------------------
module jtframe_joy_serial #(
    parameter int CLKDIV = 4,
    parameter int NBITS  = 16,
    parameter int SCAN   = 1000
)(
    input  logic                 clk_sys,
    input  logic                 rst_n,
    jtframe_joy_serial_if.master bus
);
    localparam int HALF   = NBITS / 2;
    localparam int DIV_W  = $clog2(CLKDIV);
    localparam int SCAN_W = $clog2(SCAN);
    localparam int BIT_W  = $clog2(NBITS + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_LO,
        ST_LOAD_HI,
        ST_SHIFT_LO,
        ST_SHIFT_HI,
        ST_DONE
    } state_t;

    state_t             r_state;
    logic [1:0]         r_rst_sync;
    logic               w_rst_n;
    logic [1:0]         r_data_sync;
    logic [SCAN_W-1:0]  r_scan;
    logic [DIV_W-1:0]   r_div;
    logic [BIT_W-1:0]   r_bit;
    logic [NBITS-1:0]   r_raw;
    logic [NBITS-1:0]   r_prev;
    logic [HALF-1:0]    r_joy1;
    logic [HALF-1:0]    r_joy2;
    logic               r_load;
    logic               r_clk;
    logic               r_frame_done;
    logic               w_div_end;
    logic               w_start;

    // Reset asserts asynchronously everywhere but releases on a clock edge,
    // so no flop sees the release too close to clk_sys.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) r_rst_sync <= 2'b00;
        else        r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    // JOY_DATA comes straight off the connector and is asynchronous.
    always_ff @(posedge clk_sys) begin
        r_data_sync <= {r_data_sync[0], bus.JOY_DATA};
    end

    // Free-running scan period counter; parked at 0 while scanning is disabled
    // so that re-enabling starts a frame right away.
    always_ff @(posedge clk_sys or negedge w_rst_n) begin
        if (!w_rst_n)                          r_scan <= '0;
        else if (!bus.en)                      r_scan <= '0;
        else if (r_scan == SCAN_W'(SCAN - 1))  r_scan <= '0;
        else                                   r_scan <= r_scan + 1'b1;
    end

    assign w_div_end = (r_div == DIV_W'(CLKDIV - 1));
    assign w_start   = bus.en && (r_scan == '0) && (r_state == ST_IDLE);

    // Capture shift register: every sample enters at the LSB, so after NBITS
    // samples the first bit read from the chain sits in the MSB.
    always_ff @(posedge clk_sys) begin
        if (r_state == ST_SHIFT_LO && w_div_end)
            r_raw <= {r_raw[NBITS-2:0], r_data_sync[1]};
    end

    always_ff @(posedge clk_sys or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state      <= ST_IDLE;
            r_div        <= '0;
            r_bit        <= '0;
            r_load       <= 1'b1;
            r_clk        <= 1'b0;
            r_frame_done <= 1'b0;
            r_prev       <= '1;
            r_joy1       <= '0;
            r_joy2       <= '0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state <= ST_LOAD_LO;
                        r_load  <= 1'b0;
                        r_div   <= '0;
                        r_bit   <= '0;
                    end
                end
                ST_LOAD_LO: begin
                    if (w_div_end) begin
                        r_state <= ST_LOAD_HI;
                        r_load  <= 1'b1;
                        r_div   <= '0;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                ST_LOAD_HI: begin
                    if (w_div_end) begin
                        r_state <= ST_SHIFT_LO;
                        r_div   <= '0;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                ST_SHIFT_LO: begin
                    if (w_div_end) begin
                        r_state <= ST_SHIFT_HI;
                        r_clk   <= 1'b1;
                        r_div   <= '0;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                ST_SHIFT_HI: begin
                    if (w_div_end) begin
                        r_clk <= 1'b0;
                        r_div <= '0;
                        r_bit <= r_bit + 1'b1;
                        // r_bit still holds the old count: last bit just shifted.
                        if (r_bit == BIT_W'(NBITS - 1)) begin
                            r_state      <= ST_DONE;
                            r_frame_done <= 1'b1;
                        end else begin
                            r_state <= ST_SHIFT_LO;
                        end
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                ST_DONE: begin
                    // Two consecutive identical frames are needed to update the
                    // outputs; a single glitched frame only lands in r_prev.
                    if (r_raw == r_prev) begin
                        r_joy1 <= ~r_raw[NBITS-1:HALF];
                        r_joy2 <= ~r_raw[HALF-1:0];
                    end
                    r_prev  <= r_raw;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.JOY_LOAD   = r_load;
    assign bus.JOY_CLK    = r_clk;
    assign bus.frame_done = r_frame_done;
    assign bus.joy1       = bus.swap ? r_joy2 : r_joy1;
    assign bus.joy2       = bus.swap ? r_joy1 : r_joy2;

endmodule

// File: tb/tb_jtframe_joy_serial.sv
// -----------------------------------------------------------------------------
// tb_jtframe_joy_serial
// Directed bench for jtframe_joy_serial at CLKDIV=4, NBITS=16, SCAN=400 with a
// behavioural 74HC165 chain model driving JOY_DATA.
// -----------------------------------------------------------------------------
module tb_jtframe_joy_serial;
    localparam int CLKDIV = 4;
    localparam int NBITS  = 16;
    localparam int SCAN   = 400;

    logic clk_sys = 1'b0;
    logic rst_n   = 1'b1;
    int   cyc     = 0;
    int   n_checks = 0;
    int   n_fails  = 0;

    logic [15:0] chain_val = 16'hFFFF;
    logic [15:0] sr        = 16'hFFFF;
    logic        clk_q     = 1'b0;

    jtframe_joy_serial_if #(.NBITS(NBITS)) jif ();

    jtframe_joy_serial #(
        .CLKDIV (CLKDIV),
        .NBITS  (NBITS),
        .SCAN   (SCAN)
    ) dut (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .bus     (jif.master)
    );

    always #5 clk_sys = ~clk_sys;
    always @(posedge clk_sys) cyc <= cyc + 1;

    // 74HC165 chain: parallel load while JOY_LOAD low, shift on JOY_CLK rise,
    // serial output is the MSB, ones shifted in behind.
    always @(posedge clk_sys) begin
        if (jif.JOY_LOAD === 1'b0)
            sr <= chain_val;
        else if (jif.JOY_CLK === 1'b1 && clk_q === 1'b0)
            sr <= {sr[14:0], 1'b1};
        clk_q <= jif.JOY_CLK;
    end
    assign jif.JOY_DATA = sr[15];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_load_fall(output int ts);
        int n;
        n  = 0;
        ts = -1;
        while (jif.JOY_LOAD !== 1'b0 && n < 1000) begin
            @(negedge clk_sys);
            n++;
        end
        if (jif.JOY_LOAD === 1'b0) ts = cyc;
    endtask

    // Measures one frame from the first JOY_LOAD-low cycle up to frame_done.
    task automatic run_frame(output int ts, output int lo, output int rises, output int td);
        int   n;
        logic pclk;
        lo = 0; rises = 0; td = -1;
        wait_load_fall(ts);
        if (ts < 0) return;
        pclk = jif.JOY_CLK;
        n = 0;
        while (jif.frame_done !== 1'b1 && n < 300) begin
            if (jif.JOY_LOAD === 1'b0) lo++;
            if (jif.JOY_CLK === 1'b1 && pclk === 1'b0) rises++;
            pclk = jif.JOY_CLK;
            @(negedge clk_sys);
            n++;
        end
        if (jif.frame_done === 1'b1) td = cyc;
    endtask

    initial begin
        int ts, lo, rises, td, ts2, hits;
        jif.en   = 1'b1;
        jif.swap = 1'b0;
        #2 rst_n = 1'b0;
        repeat (4) @(negedge clk_sys);
        check("rst_load", jif.JOY_LOAD, 1);
        check("rst_clk",  jif.JOY_CLK, 0);
        check("rst_joy1", jif.joy1, 0);
        check("rst_joy2", jif.joy2, 0);
        check("rst_done", jif.frame_done, 0);
        rst_n = 1'b1;

        // Test 1: idle chain timing
        run_frame(ts, lo, rises, td);
        check("t1_start_seen", (ts >= 0), 1);
        check("t1_load_len", lo, 4);
        check("t1_clk_rises", rises, 16);
        check("t1_done_cycle", td - ts, 136);
        @(negedge clk_sys);
        check("t1_done_pulse", jif.frame_done, 0);
        check("t1_joy1", jif.joy1, 8'h00);
        check("t1_joy2", jif.joy2, 8'h00);
        run_frame(ts2, lo, rises, td);
        check("t1_period", ts2 - ts, 400);

        // Test 2: pressed pattern needs two frames
        chain_val = 16'h7FFE;
        run_frame(ts, lo, rises, td);
        @(negedge clk_sys);
        check("t2_f1_joy1", jif.joy1, 8'h00);
        check("t2_f1_joy2", jif.joy2, 8'h00);
        run_frame(ts, lo, rises, td);
        check("t2_f2_pre_joy1", jif.joy1, 8'h00);
        @(negedge clk_sys);
        check("t2_f2_joy1", jif.joy1, 8'h80);
        check("t2_f2_joy2", jif.joy2, 8'h01);

        // Test 4: swap is combinational
        jif.swap = 1'b1;
        #1;
        check("t4_swap_joy1", jif.joy1, 8'h01);
        check("t4_swap_joy2", jif.joy2, 8'h80);
        jif.swap = 1'b0;
        #1;
        check("t4_unswap_joy1", jif.joy1, 8'h80);
        check("t4_unswap_joy2", jif.joy2, 8'h01);

        // Test 3: settle on released, then a single glitched frame
        chain_val = 16'hFFFF;
        run_frame(ts, lo, rises, td);
        @(negedge clk_sys);
        check("t3_hold_joy1", jif.joy1, 8'h80);
        run_frame(ts, lo, rises, td);
        @(negedge clk_sys);
        check("t3_stable_joy1", jif.joy1, 8'h00);
        chain_val = 16'h00FF;
        run_frame(ts, lo, rises, td);
        @(negedge clk_sys);
        check("t3_glitch_joy1", jif.joy1, 8'h00);
        chain_val = 16'hFFFF;
        run_frame(ts, lo, rises, td);
        @(negedge clk_sys);
        check("t3_after1_joy1", jif.joy1, 8'h00);
        run_frame(ts, lo, rises, td);
        @(negedge clk_sys);
        check("t3_after2_joy1", jif.joy1, 8'h00);

        // Test 5: reset in the middle of a frame
        chain_val = 16'h7FFE;
        run_frame(ts, lo, rises, td);
        run_frame(ts, lo, rises, td);
        @(negedge clk_sys);
        check("t5_pre_joy1", jif.joy1, 8'h80);
        check("t5_pre_joy2", jif.joy2, 8'h01);
        wait_load_fall(ts);
        repeat (70) @(negedge clk_sys);
        check("t5_clk_high_bit7", jif.JOY_CLK, 1);
        rst_n = 1'b0;
        #1;
        check("t5_rst_clk", jif.JOY_CLK, 0);
        check("t5_rst_load", jif.JOY_LOAD, 1);
        check("t5_rst_joy1", jif.joy1, 8'h00);
        check("t5_rst_joy2", jif.joy2, 8'h00);
        repeat (3) @(negedge clk_sys);
        rst_n = 1'b1;
        run_frame(ts, lo, rises, td);
        check("t5_f1_done_cycle", td - ts, 136);
        @(negedge clk_sys);
        check("t5_f1_joy1", jif.joy1, 8'h00);
        run_frame(ts, lo, rises, td);
        @(negedge clk_sys);
        check("t5_f2_joy1", jif.joy1, 8'h80);
        check("t5_f2_joy2", jif.joy2, 8'h01);

        // Test 6: scanning disabled from reset
        rst_n  = 1'b0;
        jif.en = 1'b0;
        repeat (3) @(negedge clk_sys);
        rst_n = 1'b1;
        hits = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk_sys);
            if (jif.JOY_LOAD === 1'b0 || jif.frame_done === 1'b1) hits++;
        end
        check("t6_no_activity", hits, 0);
        jif.en = 1'b1;
        @(negedge clk_sys);
        check("t6_start_next", jif.JOY_LOAD, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/jtframe_joy_serial.md
Name: jtframe_joy_serial

Overview:
Serial joystick front-end for the Cyclone V board target. It drives a 74HC165-style parallel-in/serial-out chain through JOY_LOAD, JOY_CLK and JOY_DATA, and captures one NBITS frame per scan period. Each frame is debounced by two-frame agreement and delivered as active-high joystick words. It sits directly upstream of the framework top level and feeds the joystick words that go to the board/OSD logic.

Parameters:
CLKDIV, 4, clk_sys cycles per JOY_CLK half-period and per load phase; must be >=4.
NBITS, 16, bits per frame; even, 4..32. Upper half belongs to joystick 1, lower half to joystick 2.
SCAN, 1000, clk_sys cycles between frame starts; must be > (2+2*NBITS)*CLKDIV.

Ports:
clk_sys  in  1  system clock; everything is clocked on the rising edge.
rst_n  in  1  asynchronous active-low reset.
en  in  1  scan enable; low = no new frame starts.
swap  in  1  swap the joy1/joy2 outputs (combinational mux on registered values).
JOY_LOAD  out  1  shift-register parallel load, active low.
JOY_CLK  out  1  shift clock; idles low.
JOY_DATA  in  1  serial data from the chain; active-low buttons; asynchronous.
joy1  out  NBITS/2  joystick 1, active high, registered.
joy2  out  NBITS/2  joystick 2, active high, registered.
frame_done  out  1  one-cycle pulse after each completed frame.

Behaviour:
- Reset (asynchronous assert, synchronous release internally):
  - JOY_LOAD=1, JOY_CLK=0, joy1=joy2=0, frame_done=0.
  - State IDLE; scan counter=0; bit counter=0; prev frame=all ones (released).
- JOY_DATA passes through a 2-FF synchronizer; sampling always uses the synchronized value.
- Scan counter counts 0..SCAN-1 and wraps, free-running while en=1.
  - It is held at 0 while en=0.
  - A frame starts when the counter is 0 and state is IDLE.
- State machine:
  - IDLE: wait for a frame start.
  - LOAD_LO: JOY_LOAD=0 for CLKDIV cycles.
  - LOAD_HI: JOY_LOAD=1 for CLKDIV cycles (settle).
  - SHIFT_LO: JOY_CLK=0 for CLKDIV cycles. On the last cycle, sample the synchronized data into raw[NBITS-1-bit].
  - SHIFT_HI: JOY_CLK=1 for CLKDIV cycles. Then bit++. If bit==NBITS go to DONE, else go to SHIFT_LO.
  - DONE: one cycle. frame_done=1, evaluate the filter, go to IDLE.
- Frame length from frame start to the DONE cycle is exactly (2+2*NBITS)*CLKDIV cycles. JOY_CLK produces exactly NBITS rising edges per frame.
- Bit order: the first bit sampled lands in the MSB.
  - raw[NBITS-1:NBITS/2] maps to joystick 1.
  - raw[NBITS/2-1:0] maps to joystick 2.
- Filter, in DONE:
  - If raw==prev: joy1 = ~raw upper half, joy2 = ~raw lower half, valid from the next cycle.
  - If raw!=prev: outputs hold.
  - prev<=raw in both cases.
  - Result: a single glitched frame never reaches the outputs; a real change appears after 2 frames.
- swap=1 exchanges joy1/joy2 at the outputs combinationally; the stored state is unaffected.
- en dropping mid-frame: the current frame completes normally; no new frame starts until en=1.
- Reset mid-frame: lines return to idle immediately, the partial frame is discarded, and the outputs clear.

Test Plan:
(All at CLKDIV=4, NBITS=16, SCAN=400.)
1. Release reset with JOY_DATA=1 constant -> JOY_LOAD low exactly 4 cycles from frame start. 16 JOY_CLK rising edges. frame_done at cycle 136 relative to frame start. joy1=joy2=0. Next frame starts 400 cycles after the first.
2. Chain model holds 16'h7FFE (joy1 bit7 and joy2 bit0 pressed) -> after frame 1 outputs stay 0. After frame 2, joy1=8'h80 and joy2=8'h01.
3. One-frame glitch: stable 16'hFFFF, then one frame of 16'h00FF, then 16'hFFFF again -> joy1 stays 8'h00 throughout.
4. Scenario 2 stable, then assert swap -> joy1=8'h01 and joy2=8'h80 in the same cycle. Deassert swap -> values restore.
5. Assert rst_n=0 at bit 7 of a frame where outputs are 8'h80/8'h01 -> JOY_CLK=0, JOY_LOAD=1 and joy1=joy2=0 immediately. After release, the first full frame does not update the outputs; the second does.
6. en=0 from reset for 1000 cycles -> JOY_LOAD never asserted and frame_done never pulses. Set en=1 -> a frame starts on the next cycle (counter 0).
